odd_issue_ctrl: RTL and testbench

In-order issue controller for the odd pipe (Permute / LocalStore / Branch units). It accepts decoded instructions from decode over a valid/ready handshake and stalls on RAW hazards using a self-timed destination scoreboard. It drives the registered RF-stage issue fields (op, format, unit, rt_addr, reg_write) into the odd pipe. It also serialises branches: issue halts until the branch resolves, and a taken branch produces a one-cycle flush to fetch/decode.

---
 rtl/odd_pkg.sv | 36 +++
 rtl/odd_scoreboard.sv | 56 +++++
 rtl/odd_issue_ctrl.sv | 115 +++++++++++
 tb/tb_odd_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/odd_pkg.sv
// rtl/odd_pkg.sv - shared types and latencies for the odd-pipe issue controller
package odd_pkg;

  typedef enum logic [1:0] {
    UNIT_PERM = 2'd0,
    UNIT_LS   = 2'd1,
    UNIT_BR   = 2'd2
  } unit_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  // Scoreboard index at which each unit's result reaches the forward stage
  localparam int READY_BR   = 1;
  localparam int READY_PERM = 4;
  localparam int READY_LS   = 6;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [0:6] addr;
    logic [1:0] unit;
  } sb_entry_t;

  function automatic int ready_lat(input logic [1:0] unit);
    case (unit)
      2'd1:    return READY_LS;
      2'd2:    return READY_BR;
      default: return READY_PERM;  // unit 3 behaves as Perm
    endcase
  endfunction

endpackage

// File: rtl/odd_scoreboard.sv
// rtl/odd_scoreboard.sv - self-timed destination scoreboard with three-source RAW match
module odd_scoreboard
  import odd_pkg::*;
#(
  parameter int WB_DEPTH = 8,
  parameter bit FWD_EN   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       push_write,
  input  logic [0:6] push_addr,
  input  logic [1:0] push_unit,
  input  logic [0:6] ra_addr,
  input  logic [0:6] rb_addr,
  input  logic [0:6] rc_addr,
  input  logic [2:0] src_used,
  output logic       hazard
);

  sb_entry_t entries [WB_DEPTH];
  logic [WB_DEPTH-1:0] live;

  // Entry index equals cycles since issue; falling off the end is retirement
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < WB_DEPTH; k++) entries[k] <= '0;
    end else begin
      entries[0] <= push ? sb_entry_t'{valid: 1'b1, write: push_write,
                                       addr: push_addr, unit: push_unit}
                         : '0;
      for (int k = 1; k < WB_DEPTH; k++) entries[k] <= entries[k-1];
    end
  end

  always_comb begin
    live = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      live[k] = entries[k].valid & entries[k].write &
                (FWD_EN ? (k < ready_lat(entries[k].unit)) : 1'b1);
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (live[k]) begin
        hazard = hazard |
                 (src_used[0] & (entries[k].addr == ra_addr)) |
                 (src_used[1] & (entries[k].addr == rb_addr)) |
                 (src_used[2] & (entries[k].addr == rc_addr));
      end
    end
  end

endmodule

// File: rtl/odd_issue_ctrl.sv
// rtl/odd_issue_ctrl.sv - in-order odd-pipe issue with RAW stall and branch serialisation
module odd_issue_ctrl
  import odd_pkg::*;
#(
  parameter int WB_DEPTH = 8,
  parameter int BR_LAT   = 2,
  parameter bit FWD_EN   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [0:10] dec_op,
  input  logic [2:0]  dec_format,
  input  logic [1:0]  dec_unit,
  input  logic [0:6]  dec_rt_addr,
  input  logic        dec_reg_write,
  input  logic [0:6]  dec_ra_addr,
  input  logic [0:6]  dec_rb_addr,
  input  logic [0:6]  dec_rc_addr,
  input  logic [2:0]  dec_src_used,
  input  logic        branch_taken,
  output logic        iss_valid,
  output logic [0:10] iss_op,
  output logic [2:0]  iss_format,
  output logic [1:0]  iss_unit,
  output logic [0:6]  iss_rt_addr,
  output logic        iss_reg_write,
  output logic        flush,
  output logic        hazard_stall
);

  localparam int CW = (BR_LAT < 2) ? 1 : $clog2(BR_LAT + 1);

  state_e        state, state_nxt;
  logic [CW-1:0] br_cnt;
  logic          hazard;
  logic          issue;
  logic          is_branch;

  assign issue     = dec_valid & dec_ready;
  assign is_branch = (dec_unit == UNIT_BR);

  odd_scoreboard #(
    .WB_DEPTH (WB_DEPTH),
    .FWD_EN   (FWD_EN)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .push       (issue),
    .push_write (dec_reg_write),
    .push_addr  (dec_rt_addr),
    .push_unit  (dec_unit),
    .ra_addr    (dec_ra_addr),
    .rb_addr    (dec_rb_addr),
    .rc_addr    (dec_rc_addr),
    .src_used   (dec_src_used),
    .hazard     (hazard)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)                   br_cnt <= '0;
    else if (issue && is_branch) br_cnt <= CW'(BR_LAT);
    else if (state == ST_BR_WAIT) br_cnt <= br_cnt - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:     if (issue && is_branch) state_nxt = ST_BR_WAIT;
      ST_BR_WAIT: if (br_cnt == CW'(1)) state_nxt = branch_taken ? ST_FLUSH : ST_RUN;
      ST_FLUSH:   state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // Outputs depend on registered state and scoreboard only, never on branch_taken
  always_comb begin
    dec_ready    = 1'b0;
    flush        = 1'b0;
    hazard_stall = 1'b0;
    case (state)
      ST_RUN: begin
        dec_ready    = ~hazard;
        hazard_stall = dec_valid & hazard;
      end
      ST_FLUSH: flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !issue) begin
      iss_valid     <= 1'b0;
      iss_op        <= '0;
      iss_format    <= '0;
      iss_unit      <= '0;
      iss_rt_addr   <= '0;
      iss_reg_write <= 1'b0;
    end else begin
      iss_valid     <= 1'b1;
      iss_op        <= dec_op;
      iss_format    <= dec_format;
      iss_unit      <= dec_unit;
      iss_rt_addr   <= dec_rt_addr;
      iss_reg_write <= dec_reg_write;
    end
  end

endmodule

// File: tb/tb_odd_issue_ctrl.sv
// tb/tb_odd_issue_ctrl.sv - randomized and directed bench for odd_issue_ctrl against a timeline model
module tb_odd_issue_ctrl;

  localparam int WB_DEPTH = 8;
  localparam int BR_LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        dv  [2];
  logic [0:10] dop [2];
  logic [2:0]  dfmt[2];
  logic [1:0]  dun [2];
  logic [0:6]  drt [2];
  logic        dwr [2];
  logic [0:6]  dra [2];
  logic [0:6]  drb [2];
  logic [0:6]  drc [2];
  logic [2:0]  dus [2];
  logic        btk [2];

  logic dr0, iv0, iwr0, fl0, hs0, dr1, iv1, iwr1, fl1, hs1;
  logic [0:10] iop0, iop1;
  logic [2:0]  ifmt0, ifmt1;
  logic [1:0]  iun0, iun1;
  logic [0:6]  irt0, irt1;

  odd_issue_ctrl #(.WB_DEPTH(WB_DEPTH), .BR_LAT(BR_LAT), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .reset(rst[0]), .dec_valid(dv[0]), .dec_ready(dr0),
    .dec_op(dop[0]), .dec_format(dfmt[0]), .dec_unit(dun[0]), .dec_rt_addr(drt[0]),
    .dec_reg_write(dwr[0]), .dec_ra_addr(dra[0]), .dec_rb_addr(drb[0]), .dec_rc_addr(drc[0]),
    .dec_src_used(dus[0]), .branch_taken(btk[0]), .iss_valid(iv0), .iss_op(iop0),
    .iss_format(ifmt0), .iss_unit(iun0), .iss_rt_addr(irt0), .iss_reg_write(iwr0),
    .flush(fl0), .hazard_stall(hs0));

  odd_issue_ctrl #(.WB_DEPTH(WB_DEPTH), .BR_LAT(BR_LAT), .FWD_EN(1'b1)) dut1 (
    .clk(clk), .reset(rst[1]), .dec_valid(dv[1]), .dec_ready(dr1),
    .dec_op(dop[1]), .dec_format(dfmt[1]), .dec_unit(dun[1]), .dec_rt_addr(drt[1]),
    .dec_reg_write(dwr[1]), .dec_ra_addr(dra[1]), .dec_rb_addr(drb[1]), .dec_rc_addr(drc[1]),
    .dec_src_used(dus[1]), .branch_taken(btk[1]), .iss_valid(iv1), .iss_op(iop1),
    .iss_format(ifmt1), .iss_unit(iun1), .iss_rt_addr(irt1), .iss_reg_write(iwr1),
    .flush(fl1), .hazard_stall(hs1));

  typedef struct {
    logic [0:10] op;
    logic [2:0]  fmt;
    logic [1:0]  unit;
    logic [0:6]  rt;
    logic        wr;
    logic [0:6]  ra;
    logic [0:6]  rb;
    logic [0:6]  rc;
    logic [2:0]  used;
  } ins_t;

  // One in-flight producer: the edge it issued at and what it writes
  typedef struct {
    int e;
    bit wr;
    int addr;
    int unit;
  } prod_t;

  int    total = 0;
  int    bad   = 0;
  int    n;
  prod_t prods[$];
  int    blk_until, flush_at, br_edge, force_tk;
  bit    br_pend, br_tk, fwd_cur, exp_iv;
  ins_t  exp_iss;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int op, input int fmt, input int unit, input int rt, input bit wr,
                              input int ra, input int rb, input int rc, input int used);
    ins_t x;
    x.op = 11'(op); x.fmt = 3'(fmt); x.unit = 2'(unit); x.rt = 7'(rt); x.wr = wr;
    x.ra = 7'(ra); x.rb = 7'(rb); x.rc = 7'(rc); x.used = 3'(used);
    return x;
  endfunction

  function automatic int ready_of(input int unit);
    if (unit == 1) return 6;
    if (unit == 2) return 1;
    return 4;
  endfunction

  // Busy when the producer's age before edge n is inside its blocking window
  function automatic bit busy(input int a);
    foreach (prods[i]) begin
      int age;
      int lim;
      age = n - 1 - prods[i].e;
      lim = fwd_cur ? ready_of(prods[i].unit) : WB_DEPTH;
      if (prods[i].wr && prods[i].addr == a && age < lim) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [0:6] raddr();
    if ($urandom_range(0, 3) == 0) return 7'($urandom_range(0, 127));
    return 7'($urandom_range(0, 5));
  endfunction

  function automatic ins_t rnd_ins();
    int u;
    u = $urandom_range(0, 9);
    return mk($urandom_range(0, 2047), $urandom_range(0, 7),
              (u < 4) ? 0 : (u < 7) ? 1 : (u < 8) ? 2 : 3,
              int'(raddr()), bit'($urandom_range(0, 3) != 0),
              int'(raddr()), int'(raddr()), int'(raddr()), $urandom_range(0, 7));
  endfunction

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    dv[d]  = 1'b0;
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
    prods.delete();
    n         = n + 1;
    blk_until = 0;
    flush_at  = -1;
    br_pend   = 1'b0;
    exp_iv    = 1'b0;
    exp_iss   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd_cur   = (d == 1);
  endtask

  // Drive one cycle on instance d, compare every output, then advance the model
  task automatic cyc(input int d, input bit v, input ins_t x, output bit issued);
    bit hz, er, eh, ef;
    logic g_dr, g_hs, g_fl, g_iv, g_wr;
    logic [0:10] g_op;
    logic [2:0] g_fmt;
    logic [1:0] g_un;
    logic [0:6] g_rt;
    dv[d] = v; dop[d] = x.op; dfmt[d] = x.fmt; dun[d] = x.unit; drt[d] = x.rt;
    dwr[d] = x.wr; dra[d] = x.ra; drb[d] = x.rb; drc[d] = x.rc; dus[d] = x.used;
    btk[d] = (br_pend && n == br_edge + BR_LAT) ? br_tk : 1'($urandom_range(0, 1));
    @(negedge clk);
    hz = (x.used[0] && busy(int'(x.ra))) || (x.used[1] && busy(int'(x.rb))) ||
         (x.used[2] && busy(int'(x.rc)));
    er = (n >= blk_until) && !hz;
    eh = v && (n >= blk_until) && hz;
    ef = (n == flush_at);
    g_dr = d ? dr1 : dr0;   g_hs = d ? hs1 : hs0;     g_fl = d ? fl1 : fl0;
    g_iv = d ? iv1 : iv0;   g_wr = d ? iwr1 : iwr0;   g_op = d ? iop1 : iop0;
    g_fmt = d ? ifmt1 : ifmt0; g_un = d ? iun1 : iun0; g_rt = d ? irt1 : irt0;
    check_eq("dec_ready", 32'(g_dr), 32'(er));
    check_eq("hazard_stall", 32'(g_hs), 32'(eh));
    check_eq("flush", 32'(g_fl), 32'(ef));
    check_eq("iss_valid", 32'(g_iv), 32'(exp_iv));
    check_eq("iss_op", 32'(g_op), 32'(exp_iss.op));
    check_eq("iss_format", 32'(g_fmt), 32'(exp_iss.fmt));
    check_eq("iss_unit", 32'(g_un), 32'(exp_iss.unit));
    check_eq("iss_rt_addr", 32'(g_rt), 32'(exp_iss.rt));
    check_eq("iss_reg_write", 32'(g_wr), 32'(exp_iss.wr));
    issued = v && er;
    @(posedge clk);
    #1;
    if (issued) begin
      exp_iv  = 1'b1;
      exp_iss = x;
      prods.push_back('{n, x.wr, int'(x.rt), int'(x.unit)});
      if (x.unit == 2'd2) begin
        br_tk     = (force_tk < 0) ? 1'($urandom_range(0, 1)) : 1'(force_tk);
        br_pend   = 1'b1;
        br_edge   = n;
        blk_until = n + BR_LAT + (br_tk ? 2 : 1);
        flush_at  = br_tk ? n + BR_LAT + 1 : -1;
      end
    end else begin
      exp_iv  = 1'b0;
      exp_iss = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    n++;
    while (prods.size() > 0 && n - 1 - prods[0].e >= WB_DEPTH) void'(prods.pop_front());
  endtask

  task automatic issue_wait(input int d, input ins_t x, output int waits);
    bit iss;
    waits = 0;
    iss   = 1'b0;
    for (int i = 0; i < 40 && !iss; i++) begin
      cyc(d, 1'b1, x, iss);
      if (!iss) waits++;
    end
    if (!iss) check_eq("issue_timeout", 32'(iss), 32'd1);
  endtask

  task automatic random_phase(input int d, input int cycles);
    ins_t cur;
    bit   have, iss;
    have     = 1'b0;
    force_tk = -1;
    for (int c = 0; c < cycles; c++) begin
      if (!have || $urandom_range(0, 7) == 0) begin
        cur  = rnd_ins();
        have = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset(d);
      end else begin
        cyc(d, bit'($urandom_range(0, 3) != 0), cur, iss);
        if (iss) have = 1'b0;
      end
    end
  endtask

  ins_t idle;
  bit   iss;
  int   w;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; dv[d] = 1'b0; dop[d] = '0; dfmt[d] = '0; dun[d] = '0; drt[d] = '0;
      dwr[d] = 1'b0; dra[d] = '0; drb[d] = '0; drc[d] = '0; dus[d] = '0; btk[d] = 1'b0;
    end
    n = 0;
    force_tk = -1;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Instance 0: no forwarding
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b1, mk(i + 1, i, 0, 10 + i, 1'b1, 1, 2, 0, 3), iss);
      check_eq("indep_issue", 32'(iss), 32'd1);
    end
    cyc(0, 1'b0, idle, iss);
    issue_wait(0, mk(100, 1, 0, 5, 1'b1, 0, 0, 0, 0), w);
    issue_wait(0, mk(101, 1, 0, 6, 1'b1, 5, 0, 0, 1), w);
    check_eq("fwd0_stall", 32'(w), 32'(WB_DEPTH));
    issue_wait(0, mk(102, 2, 0, 9, 1'b0, 0, 0, 0, 0), w);
    cyc(0, 1'b1, mk(103, 2, 1, 11, 1'b1, 9, 9, 9, 7), iss);
    check_eq("nowrite_nostall", 32'(iss), 32'd1);
    cyc(0, 1'b1, mk(104, 3, 0, 33, 1'b1, 33, 0, 33, 5), iss);
    check_eq("self_read", 32'(iss), 32'd1);
    force_tk = 1;
    issue_wait(0, mk(200, 4, 2, 0, 1'b0, 0, 0, 0, 0), w);
    issue_wait(0, mk(201, 4, 0, 50, 1'b1, 1, 2, 3, 0), w);
    check_eq("br_taken_gap", 32'(w), 32'(BR_LAT + 1));
    force_tk = 0;
    issue_wait(0, mk(202, 4, 2, 40, 1'b1, 0, 0, 0, 0), w);
    issue_wait(0, mk(203, 4, 0, 51, 1'b1, 1, 2, 3, 0), w);
    check_eq("br_nt_gap", 32'(w), 32'(BR_LAT));
    issue_wait(0, mk(204, 5, 1, 52, 1'b1, 40, 0, 0, 1), w);
    check_eq("br_wr_sb", 32'(w), 32'(WB_DEPTH - BR_LAT - 1));
    force_tk = 1;
    issue_wait(0, mk(205, 0, 0, 20, 1'b1, 0, 0, 0, 0), w);
    issue_wait(0, mk(206, 0, 2, 0, 1'b0, 0, 0, 0, 0), w);
    cyc(0, 1'b0, idle, iss);
    do_reset(0);
    cyc(0, 1'b1, mk(207, 0, 0, 21, 1'b1, 20, 0, 0, 1), iss);
    check_eq("rst_brwait_clear", 32'(iss), 32'd1);
    random_phase(0, 1500);
    dv[0] = 1'b0;

    // Instance 1: forwarding enabled
    do_reset(1);
    force_tk = -1;
    issue_wait(1, mk(300, 0, 1, 7, 1'b1, 0, 0, 0, 0), w);
    issue_wait(1, mk(301, 0, 0, 8, 1'b1, 7, 0, 0, 1), w);
    check_eq("fwd1_ls_stall", 32'(w), 32'd6);
    issue_wait(1, mk(302, 0, 0, 12, 1'b1, 0, 8, 0, 2), w);
    check_eq("fwd1_perm_stall", 32'(w), 32'd4);
    issue_wait(1, mk(303, 0, 0, 14, 1'b1, 0, 0, 0, 0), w);
    issue_wait(1, mk(304, 0, 3, 15, 1'b1, 0, 0, 14, 4), w);
    check_eq("fwd1_unit3_stall", 32'(w), 32'd4);
    random_phase(1, 1500);
    dv[1] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
